// File: rtl/bounce_gen.sv
// bounce_gen: emulates a bouncing mechanical button from a clean level; define BOUNCE_GEN_RELEASE_BOUNCE_EN to bounce releases too
module bounce_gen #(
    parameter int unsigned BOUNCE_CYCLES = 50,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_i,
    output logic       but_o,
    output logic       busy_o,
    output logic [7:0] edge_cnt_o
);
    typedef enum logic {IDLE, BOUNCE} state_t;
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] CNT_INIT = 16'(BOUNCE_CYCLES - 1);
`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
    localparam bit REL_BOUNCE = 1'b1;
`else
    localparam bit REL_BOUNCE = 1'b0;
`endif
    state_t      state, state_n;
    logic        lvl, lvl_n, tgt, tgt_n, but_n, busy_n;
    logic        change, fast, start, abort, settle;
    logic [15:0] cnt, cnt_n, lfsr, lfsr_n;
    logic [7:0]  edge_n;
    // state register: every piece of state, including registered outputs, updates here
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lvl        <= 1'b0;
            tgt        <= 1'b0;
            cnt        <= 16'd0;
            lfsr       <= SEED;
            but_o      <= 1'b0;
            busy_o     <= 1'b0;
            edge_cnt_o <= 8'd0;
        end else begin
            state      <= state_n;
            lvl        <= lvl_n;
            tgt        <= tgt_n;
            cnt        <= cnt_n;
            lfsr       <= lfsr_n;
            but_o      <= but_n;
            busy_o     <= busy_n;
            edge_cnt_o <= edge_n;
        end
    end
    // next-state: open/restart a window, settle instantly (no window or unbounced release), abort, or finish
    always_comb begin
        change  = (state == IDLE) && (cmd_i != lvl);
        fast    = change && (BOUNCE_CYCLES == 0 || (!REL_BOUNCE && !cmd_i));
        start   = (change && !fast) || ((state == BOUNCE) && (cmd_i != tgt) && (REL_BOUNCE || cmd_i));
        abort   = (state == BOUNCE) && (cmd_i != tgt) && !REL_BOUNCE && !cmd_i;
        settle  = (state == BOUNCE) && (cmd_i == tgt) && (cnt == 16'd0);
        state_n = start ? BOUNCE : (fast || abort || settle) ? IDLE : state;
        lvl_n   = (fast || abort || settle) ? cmd_i : lvl;
        tgt_n   = (start || fast || abort) ? cmd_i : tgt;
        cnt_n   = start ? CNT_INIT : ((state == BOUNCE) && (cnt != 16'd0)) ? cnt - 16'd1 : cnt;
        lfsr_n  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
    // outputs: noise while bouncing, settled level otherwise; toggle count restarts with each window
    always_comb begin
        but_n  = (state_n == BOUNCE) ? lfsr[0] : lvl_n;
        busy_n = (state_n == BOUNCE);
        edge_n = (start || fast) ? {7'd0, but_n ^ but_o}
               : ((but_n != but_o) && (edge_cnt_o != 8'hFF)) ? edge_cnt_o + 8'd1 : edge_cnt_o;
    end
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: scoreboard bench for bounce_gen (50-cycle instance plus zero-window instance)
module tb_bounce_gen;
    localparam int          B    = 50;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif
    typedef struct packed {
        logic       but;
        logic       busy;
        logic [7:0] ecnt;
        logic       but_z;
        logic       busy_z;
        logic [7:0] ecnt_z;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, cmd = 1'b0, cmd_z = 1'b0;
    logic       but, busy, but_z, busy_z;
    logic [7:0] ecnt, ecnt_z;
    exp_t       q[$];
    logic       tr[$], tra[$];
    int         checks = 0, errors = 0, busy_cnt = 0, tog_cnt = 0, cyc = 0, diffs;
    logic       rec = 1'b0, last_but = 1'b0;
    logic       m_st = 0, m_lvl = 0, m_tgt = 0, m_but = 0, mz_but = 0;
    logic [7:0] m_edge = 0, mz_edge = 0;
    logic [15:0] m_lfsr = SEED;
    int         m_cnt = 0;

    bounce_gen #(.BOUNCE_CYCLES(B), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .cmd_i(cmd), .but_o(but), .busy_o(busy), .edge_cnt_o(ecnt));
    bounce_gen #(.BOUNCE_CYCLES(0), .LFSR_SEED(SEED)) dut_z (
        .clk(clk), .rst(rst), .cmd_i(cmd_z), .but_o(but_z), .busy_o(busy_z), .edge_cnt_o(ecnt_z));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: drive inputs, push the model's view of the outputs after the coming edge
    task automatic step(input logic r, input logic c);
        exp_t e;
        logic prev, lb, rs;
        rst = r; cmd = c; cmd_z = (cyc % 20) >= 10; cyc++;
        if (r) begin
            m_st = 0; m_lvl = 0; m_tgt = 0; m_but = 0; m_edge = 0; m_cnt = 0; m_lfsr = SEED;
            mz_but = 0; mz_edge = 0;
        end else begin
            prev = m_but; lb = m_lfsr[0]; rs = 0;
            if (!m_st) begin
                if (c != m_lvl) begin
                    rs = 1;
                    if (c || REL) begin m_st = 1; m_tgt = c; m_cnt = B - 1; m_but = lb; end
                    else begin m_lvl = 0; m_tgt = 0; m_but = 0; end
                end
            end else if (c != m_tgt) begin
                if (c || REL) begin m_tgt = c; m_cnt = B - 1; m_but = lb; rs = 1; end
                else begin m_st = 0; m_lvl = 0; m_tgt = 0; m_but = 0; end
            end else if (m_cnt != 0) begin
                m_but = lb; m_cnt--;
            end else begin
                m_st = 0; m_lvl = m_tgt; m_but = m_tgt;
            end
            if (rs) m_edge = (m_but != prev) ? 8'd1 : 8'd0;
            else if (m_but != prev && m_edge != 8'd255) m_edge++;
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'b1011_0100_0000_0000) : (m_lfsr >> 1);
            if (cmd_z != mz_but) begin mz_but = cmd_z; mz_edge = 8'd1; end
        end
        e = '{but: m_but, busy: m_st, ecnt: m_edge, but_z: mz_but, busy_z: 1'b0, ecnt_z: mz_edge};
        q.push_back(e);
        @(posedge clk); #2;
    endtask

    // monitor: pop and compare one expectation per edge, tally busy cycles and observed toggles
    initial forever begin
        exp_t e;
        @(posedge clk); #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("but_o", but, e.but);
            check("busy_o", busy, e.busy);
            check("edge_cnt_o", ecnt, e.ecnt);
            check("z_but_o", but_z, e.but_z);
            check("z_busy_o", busy_z, e.busy_z);
            check("z_edge_cnt_o", ecnt_z, e.ecnt_z);
        end
        if (rec) tr.push_back(but);
        if (busy) busy_cnt++;
        if (but !== last_but) tog_cnt++;
        last_but = but;
    end

    task automatic reset_run();
        repeat (2) step(1, 1'b0);
        repeat (25) step(0, 1'b1);
        step(1, 1'b1);
        check("rst_abort_but", but, 0);
        check("rst_abort_busy", busy, 0);
        repeat (60) step(0, 1'b1);
    endtask

    initial begin
        repeat (5) step(1, 1'b0);
        busy_cnt = 0; tog_cnt = 0;
        repeat (60) step(0, 1'b1);
        check("press_busy_cycles", busy_cnt, B);
        check("press_settled", but, 1);
        check("press_toggles", ecnt, tog_cnt);
        check("press_edges_seen", int'(ecnt != 8'd0), 1);
        repeat (60) step(0, 1'b0);
        check("release_settled", but, 0);
        repeat (19) step(0, 1'b1);
        repeat (60) step(0, 1'b0);
        check("reverse_settled", but, 0);
        check("reverse_idle", busy, 0);
        repeat (51) step(0, 1'b1);
        repeat (60) step(0, 1'b0);
        check("retoggle_settled", but, 0);
        rec = 1'b1;
        reset_run();
        rec = 1'b0;
        tra = tr;
        tr.delete();
        rec = 1'b1;
        reset_run();
        rec = 1'b0;
        check("trace_len", tr.size(), tra.size());
        diffs = 0;
        foreach (tr[i]) if (i < tra.size() && tr[i] !== tra[i]) diffs++;
        check("trace_diffs", diffs, 0);
        @(posedge clk); #2;
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
